mux_scan_serializer: RTL and testbench

Parallel-to-serial front end that accepts an 8-bit word over a valid/ready handshake and walks the select lines of an N:1 multiplexer across every input bit, one bit per accepted output beat. It drives the mux select itself and presents the selected bit as a serial stream with valid/ready/last framing. It sits directly upstream of serial consumers, such as a shift-register receiver or a UART-style bit sink.

---
 rtl/mux_ser_pkg.sv | 16 +
 rtl/mux_nx1.sv | 13 +
 rtl/mux_scan_serializer.sv | 99 +++++++++
 tb/tb_mux_scan_serializer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mux_ser_pkg.sv
// Shared types and helpers for the mux-scan serializer and its select datapath.
package mux_ser_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Select advance: down for MSB-first, up for LSB-first; caller truncates to SEL_W.
  function automatic logic [31:0] next_sel(input logic [31:0] sel, input logic msb_first);
    return msb_first ? (sel - 32'd1) : (sel + 32'd1);
  endfunction

endpackage

// File: rtl/mux_nx1.sv
// Parameterised combinational N:1 bit selector.
module mux_nx1 #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned SEL_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SEL_W-1:0] sel,
  output logic             y_c
);

  assign y_c = data[sel];

endmodule

// File: rtl/mux_scan_serializer.sv
// Accepts a parallel word and streams it out one bit per beat by walking a mux select.
module mux_scan_serializer
  import mux_ser_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  localparam int unsigned SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(WIDTH - 1);

  state_e           state, state_d;
  logic [WIDTH-1:0] held_word, held_word_d;
  logic             msb_first, msb_first_d;
  logic [SEL_W-1:0] sel_d;
  logic [SEL_W-1:0] count, count_d;
  logic             in_ready_d, ser_valid_d, ser_last_d, busy_d;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d     = state;
    held_word_d = held_word;
    msb_first_d = msb_first;
    sel_d       = sel;
    count_d     = count;

    case (state)
      IDLE: begin
        if (in_valid) begin
          held_word_d = in_data;
          msb_first_d = in_msb_first;
          sel_d       = in_msb_first ? LAST_IDX : '0;
          count_d     = '0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_ready) begin
          if (count == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            count_d = count + SEL_W'(1);
            sel_d   = SEL_W'(next_sel(32'(sel), msb_first));
          end
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    ser_valid_d = (state_d == SHIFT);
    busy_d      = (state_d == SHIFT);
    ser_last_d  = (state_d == SHIFT) && (count_d == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      held_word <= '0;
      msb_first <= 1'b0;
      sel       <= '0;
      count     <= '0;
      in_ready  <= 1'b1;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      held_word <= held_word_d;
      msb_first <= msb_first_d;
      sel       <= sel_d;
      count     <= count_d;
      in_ready  <= in_ready_d;
      ser_valid <= ser_valid_d;
      ser_last  <= ser_last_d;
      busy      <= busy_d;
    end
  end

  // Only combinational output: held word bit at the registered select.
  mux_nx1 #(.WIDTH(WIDTH)) u_mux (
    .data (held_word),
    .sel  (sel),
    .y_c  (ser_out)
  );

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Randomized self-checking bench: each beat compared against a word/order/beat-index model.
module tb_mux_scan_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_msb_first;
  logic       in_valid;
  logic       in_ready;
  logic       ser_out;
  logic       ser_valid;
  logic       ser_ready;
  logic       ser_last;
  logic [2:0] sel;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_beat_cyc = -100;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mux_scan_serializer #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_msb_first (in_msb_first),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ser_out      (ser_out),
    .ser_valid    (ser_valid),
    .ser_ready    (ser_ready),
    .ser_last     (ser_last),
    .sel          (sel),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic ready_for(input int mode, input int idx);
    logic [5:0] pat;
    pat = 6'b101001;  // index 0..5 = 1,0,0,1,0,1
    case (mode)
      0:       return 1'b1;
      1:       return pat[idx % 6];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_ser_valid"}, 32'(ser_valid), 32'd0);
    check({tag, "_ser_last"},  32'(ser_last),  32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  // Called at a negedge. Sends one word and follows every beat against the model.
  // ready_mode: 0 always, 1 fixed pattern, 2 random. hold: keep in_valid high with junk during SHIFT.
  // abort_at: nonzero asserts reset once that many beats are accepted. chk_gap: require 1 IDLE cycle.
  task automatic send_word(input logic [7:0] w, input logic msb, input int ready_mode,
                           input bit hold, input int abort_at, input bit chk_gap);
    int   k, n, acc_cyc;
    logic r, exp_bit;
    logic [7:0] ww, rebuilt;
    ww = w;
    rebuilt = '0;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    in_data = w;
    in_msb_first = msb;
    in_valid = 1'b1;
    @(posedge clk);
    acc_cyc = cyc;
    @(negedge clk);
    if (chk_gap) check("gap_cycles", 32'(acc_cyc - last_beat_cyc), 32'd1);
    in_valid = hold;
    k = 0;
    n = 0;
    while (k < 8 && n < 1000) begin
      if (abort_at != 0 && k == abort_at) begin
        rst_n = 1'b0;
        ser_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_ser_valid", 32'(ser_valid), 32'd0);
        check("rst_mid_sel",       32'(sel),       32'd0);
        check("rst_mid_in_ready",  32'(in_ready),  32'd1);
        check("rst_mid_busy",      32'(busy),      32'd0);
        check("rst_mid_ser_out",   32'(ser_out),   32'd0);
        rst_n = 1'b1;
        in_valid = 1'b0;
        return;
      end
      exp_bit = ww[msb ? 7 - k : k];
      check("ser_valid", 32'(ser_valid), 32'd1);
      check("busy",      32'(busy),      32'd1);
      check("in_ready",  32'(in_ready),  32'd0);
      check("sel",       32'(sel),       32'(msb ? 7 - k : k));
      check("ser_out",   32'(ser_out),   32'(exp_bit));
      check("ser_last",  32'(ser_last),  32'(k == 7));
      r = ready_for(ready_mode, n);
      ser_ready = r;
      if (hold) begin
        in_data = 8'($urandom);
        in_msb_first = 1'($urandom);
        in_valid = !(r && k == 7);
      end
      if (r) rebuilt[sel] = ser_out;
      @(posedge clk);
      if (r) begin
        k++;
        last_beat_cyc = cyc;
      end
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("beat_timeout", 32'd1, 32'd0);
    check("rebuilt_word", 32'(rebuilt), 32'(w));
    check_idle("post_word");
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] w;
    rst_n = 1'b0;
    in_data = '0;
    in_msb_first = 1'b0;
    in_valid = 1'b0;
    ser_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    check("reset_sel", 32'(sel), 32'd0);
    check("reset_ser_out", 32'(ser_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send_word(8'h01, 1'b0, 0, 1'b0, 0, 1'b0);
    send_word(8'hB4, 1'b1, 0, 1'b0, 0, 1'b1);

    // Walking one / walking zero in both orders, back to back.
    for (int o = 0; o < 2; o++) begin
      for (int i = 0; i < 8; i++) begin
        w = 8'(1 << i);
        send_word(w, 1'(o), 0, 1'b0, 0, 1'b1);
        send_word(~w, 1'(o), 0, 1'b0, 0, 1'b1);
      end
    end

    send_word(8'hA5, 1'b0, 1, 1'b0, 0, 1'b0);
    send_word(8'h3C, 1'b1, 0, 1'b1, 0, 1'b0);
    send_word(8'hC3, 1'b0, 2, 1'b1, 0, 1'b0);

    send_word(8'hFF, 1'b0, 0, 1'b0, 3, 1'b0);
    send_word(8'h0F, 1'b0, 0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      send_word(8'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                1'($urandom), 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
